// File: rtl/muldiv_unit_pkg.sv
// Shared constants, op codes and FSM encodings for the multi-cycle mul/div engine.
// No ports; imported by the interface, the step datapath and the top.
package muldiv_unit_pkg;

    localparam int MD_DATA_WIDTH = 32;  // operand/result width
    localparam int MD_CNT_WIDTH  = 6;   // 2**CNT_WIDTH > DATA_WIDTH
    localparam int MD_OP_WIDTH   = 2;
    // Counter preload for divide-by-zero: skips the iteration but keeps a
    // fixed two-cycle turnaround from the start edge to done.
    localparam int MD_DZ_CNT     = 1;

    typedef enum logic [MD_OP_WIDTH-1:0] {
        MD_MUL   = 2'd0,
        MD_MULHU = 2'd1,
        MD_DIVU  = 2'd2,
        MD_REMU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic md_is_div(md_op_e op);
        return (op == MD_DIVU) || (op == MD_REMU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the mul/div engine.
//   start_i, op_i, a_i, b_i, flush_i : requester -> engine
//   busy_o, done_o, result_o          : engine -> requester
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int W = MD_DATA_WIDTH
);
    logic         start_i;
    md_op_e       op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         flush_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;

    modport master (output start_i, op_i, a_i, b_i, flush_i,
                    input  busy_o, done_o, result_o);
    modport slave  (input  start_i, op_i, a_i, b_i, flush_i,
                    output busy_o, done_o, result_o);
endinterface

// File: rtl/muldiv_unit_step.sv
// muldiv_step: one combinational iteration of the engine, MSB-first.
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   a_bit_i  : current MSB of the multiplier / dividend
//   acc_i    : 2W accumulator (mul) or partial remainder in acc_i[W:0] (div)
//   b_i      : multiplicand / divisor
//   acc_o    : next accumulator / remainder
//   q_bit_o  : quotient bit (0 for multiply)
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int W = MD_DATA_WIDTH
) (
    input  logic           is_div_i,
    input  logic           a_bit_i,
    input  logic [2*W-1:0] acc_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] acc_o,
    output logic           q_bit_o
);
    logic [W:0] rem_sh;
    logic [W:0] rem_nx;

    always_comb begin
        rem_sh  = {acc_i[W-1:0], a_bit_i};
        rem_nx  = rem_sh;
        acc_o   = '0;
        q_bit_o = 1'b0;
        if (is_div_i) begin
            // Restore by simply not committing the subtraction.
            if (rem_sh >= {1'b0, b_i}) begin
                rem_nx  = rem_sh - {1'b0, b_i};
                q_bit_o = 1'b1;
            end
            acc_o = (2*W)'(rem_nx);
        end else begin
            // MSB-first shift-add; wraps mod 2**(2W).
            acc_o = {acc_i[2*W-2:0], 1'b0} + (a_bit_i ? {{W{1'b0}}, b_i} : '0);
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned MUL/MULHU/DIVU/REMU engine, one bit per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : muldiv_unit_if slave (start/op/a/b/flush in, busy/done/result out)
// All outputs are registered. done is a one-cycle pulse in the DONE state.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = MD_DATA_WIDTH,
    parameter int CNT_WIDTH  = MD_CNT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    md_state_e               state_q;
    md_op_e                  op_q;
    logic [DATA_WIDTH-1:0]   a_q;     // shifts out operand MSBs, shifts in quotient bits
    logic [DATA_WIDTH-1:0]   b_q;
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    dz_q;
    logic                    busy_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   result_q;

    logic [2*DATA_WIDTH-1:0] acc_d;
    logic                    q_bit;
    logic                    start_dz;
    logic [DATA_WIDTH-1:0]   result_d;

    assign start_dz = md_is_div(bus.op_i) && (bus.b_i == '0);

    muldiv_step #(.W(DATA_WIDTH)) u_step (
        .is_div_i (md_is_div(op_q)),
        .a_bit_i  (a_q[DATA_WIDTH-1]),
        .acc_i    (acc_q),
        .b_i      (b_q),
        .acc_o    (acc_d),
        .q_bit_o  (q_bit)
    );

    // a_q is untouched on divide-by-zero, so it still holds the dividend for REMU.
    always_comb begin
        result_d = acc_q[DATA_WIDTH-1:0];
        case (op_q)
            MD_MUL:   result_d = acc_q[DATA_WIDTH-1:0];
            MD_MULHU: result_d = acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
            MD_DIVU:  result_d = dz_q ? '1 : a_q;
            MD_REMU:  result_d = dz_q ? a_q : acc_q[DATA_WIDTH-1:0];
            default:  result_d = acc_q[DATA_WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= MD_MUL;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        op_q    <= bus.op_i;
                        a_q     <= bus.a_i;
                        b_q     <= bus.b_i;
                        acc_q   <= '0;
                        dz_q    <= start_dz;
                        cnt_q   <= start_dz ? CNT_WIDTH'(MD_DZ_CNT) : CNT_WIDTH'(DATA_WIDTH);
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.flush_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= result_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (!dz_q) begin
                            acc_q <= acc_d;
                            a_q   <= {a_q[DATA_WIDTH-2:0], q_bit};
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if bus ();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    int          n_push  = 0;
    int          n_spur  = 0;
    int          n_dbl   = 0;
    logic        prev_done = 1'b0;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input md_op_e o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (o)
            MD_MUL:   return p[31:0];
            MD_MULHU: return p[63:32];
            MD_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (bus.done_o) begin
            n_done++;
            if (prev_done) n_dbl++;
            if (sb_q.size() == 0) n_spur++;
            else chk("result", 64'(bus.result_o), 64'(sb_q.pop_front()));
        end
        prev_done = bus.done_o;
    end

    task automatic run_op(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input string tag);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = o; bus.a_i = a; bus.b_i = b;
        last_exp = model(o, a, b);
        sb_q.push_back(last_exp);
        n_push++;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        lat = 0;
        busy_ok = bus.busy_o;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (!bus.busy_o) busy_ok = 1'b0;
            if (bus.done_o) lat = k;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(busy_ok), 64'(1));
        @(posedge clk); #1;
        chk({tag, "_idle"}, 64'(bus.busy_o), 64'(0));
    endtask

    // Start an op with no expected result (it is going to be aborted).
    task automatic start_dead(input md_op_e o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = o; bus.a_i = a; bus.b_i = b;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        int accepted;
        bus.start_i = 1'b0; bus.op_i = MD_MUL; bus.a_i = '0; bus.b_i = '0; bus.flush_i = 1'b0;

        // Reset state
        #2;
        chk("rst_busy", 64'(bus.busy_o), 64'(0));
        chk("rst_done", 64'(bus.done_o), 64'(0));
        chk("rst_result", 64'(bus.result_o), 64'(0));
        @(negedge clk); rst = 1'b0;

        // Directed ops
        run_op(MD_MUL,   32'd7,         32'd6,         33, "mul7x6");
        run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhu_ff");
        run_op(MD_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mul_ff");
        run_op(MD_DIVU,  32'd100,       32'd7,         33, "divu");
        run_op(MD_REMU,  32'd100,       32'd7,         33, "remu");
        run_op(MD_DIVU,  32'd5,         32'd0,         2,  "divu_z");
        run_op(MD_REMU,  32'd5,         32'd0,         2,  "remu_z");
        run_op(MD_MUL,   32'd12345,     32'd0,         33, "mul_z");

        // Flush mid-run: no done, result holds
        start_dead(MD_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk); bus.flush_i = 1'b1;
        @(posedge clk); #1;
        chk("flush_busy", 64'(bus.busy_o), 64'(0));
        @(negedge clk); bus.flush_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("flush_result", 64'(bus.result_o), 64'(last_exp));
        run_op(MD_MUL, 32'd3, 32'd4, 33, "mul_after_flush");

        // Asynchronous reset between edges
        start_dead(MD_MUL, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy_o), 64'(0));
        chk("arst_done", 64'(bus.done_o), 64'(0));
        chk("arst_result", 64'(bus.result_o), 64'(0));
        @(negedge clk); rst = 1'b0;
        repeat (40) @(posedge clk);

        // Start held high, random ops; inputs churn while busy
        accepted = 0;
        cyc = 0;
        @(negedge clk);
        bus.op_i = md_op_e'($urandom_range(0, 3)); bus.a_i = rnd_val(); bus.b_i = rnd_val();
        bus.start_i = 1'b1;
        while (accepted < 1000 && cyc < 60000) begin
            if (!bus.busy_o) begin
                sb_q.push_back(model(bus.op_i, bus.a_i, bus.b_i));
                n_push++;
                accepted++;
            end
            @(negedge clk);
            cyc++;
            if (bus.busy_o) begin
                bus.op_i = md_op_e'($urandom_range(0, 3));
                bus.a_i = rnd_val();
                bus.b_i = rnd_val();
            end
        end
        bus.start_i = 1'b0;
        chk("rand_budget", 64'(accepted), 64'(1000));
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        chk("done_count", 64'(n_done), 64'(n_push));
        chk("done_double", 64'(n_dbl), 64'(0));
        chk("done_spurious", 64'(n_spur), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
